// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable driven counters, sync/DE decode and a
// two-stage registered output. Define VGA_TIMING_TEST_PATTERN_EN for built-in colour bars.
module vga_timing_gen #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int CW     = 8
) (
    input  logic                fpga_CLK,
    input  logic                fpga_RST,
    input  logic                pix_en,
    output logic                pix_req,
    output logic [10:0]         pix_x,
    output logic [9:0]          pix_y,
    output logic                frame_start,
    input  logic [3*CW-1:0]     rgb_in,
    output logic [3*CW-1:0]     vga_RGB,
    output logic                vga_HS,
    output logic                vga_VS,
    output logic                vga_DE
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_DISP_W = 11'(H_DISP);
    localparam logic [10:0] H_SS     = 11'(H_DISP + H_FP);
    localparam logic [10:0] H_SE     = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_DISP_W = 10'(V_DISP);
    localparam logic [9:0]  V_SS     = 10'(V_DISP + V_FP);
    localparam logic [9:0]  V_SE     = 10'(V_DISP + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic [10:0]        hcnt_r;
    logic [9:0]         vcnt_r;
    logic [10:0]        hcnt_nxt_s;
    logic [9:0]         vcnt_nxt_s;
    logic               active_s;
    logic               hs_act_s;
    logic               vs_act_s;
    logic               origin_s;

    logic               pix_req_r;
    logic [10:0]        pix_x_r;
    logic [9:0]         pix_y_r;
    logic               hs1_r;
    logic               vs1_r;
    logic               de1_r;
    logic               frame_start_r;

    logic [3*CW-1:0]    rgb_sel_s;
    logic [3*CW-1:0]    vga_rgb_r;
    logic               vga_hs_r;
    logic               vga_vs_r;
    logic               vga_de_r;

    // Next raster position: horizontal wrap carries into the line counter.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        vcnt_nxt_s = vcnt_r;
        if (hcnt_r == H_LAST) begin
            hcnt_nxt_s = 11'd0;
            if (vcnt_r == V_LAST) begin
                vcnt_nxt_s = 10'd0;
            end else begin
                vcnt_nxt_s = vcnt_r + 10'd1;
            end
        end else begin
            hcnt_nxt_s = hcnt_r + 11'd1;
            vcnt_nxt_s = vcnt_r;
        end
    end

    // Region decode of the current counter position.
    always_comb begin
        active_s = (hcnt_r < H_DISP_W) && (vcnt_r < V_DISP_W);
        hs_act_s = (hcnt_r >= H_SS) && (hcnt_r < H_SE);
        vs_act_s = (vcnt_r >= V_SS) && (vcnt_r < V_SE);
        origin_s = (hcnt_r == 11'd0) && (vcnt_r == 10'd0);
    end

    // Stage 0: raster counters.
    always_ff @(posedge fpga_CLK) begin
        if (fpga_RST) begin
            hcnt_r <= 11'd0;
            vcnt_r <= 10'd0;
        end else if (pix_en) begin
            hcnt_r <= hcnt_nxt_s;
            vcnt_r <= vcnt_nxt_s;
        end
    end

    // Stage 1: pixel request to upstream plus delayed sync/DE.
    always_ff @(posedge fpga_CLK) begin
        if (fpga_RST) begin
            pix_req_r <= 1'b0;
            pix_x_r   <= 11'd0;
            pix_y_r   <= 10'd0;
            hs1_r     <= 1'b0;
            vs1_r     <= 1'b0;
            de1_r     <= 1'b0;
        end else if (pix_en) begin
            pix_req_r <= active_s;
            pix_x_r   <= hcnt_r;
            pix_y_r   <= vcnt_r;
            hs1_r     <= hs_act_s;
            vs1_r     <= vs_act_s;
            de1_r     <= active_s;
        end
    end

    // Frame marker: a single clock, only on the tick that loads the origin.
    always_ff @(posedge fpga_CLK) begin
        if (fpga_RST) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en && origin_s;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_DISP >= 8) ? (H_DISP / 8) : 1;

    logic [10:0] bar_full_s;
    logic [2:0]  bar_idx_s;

    // Eight vertical bars; index bits map directly onto {R,G,B} all-ones or zero.
    always_comb begin
        bar_full_s = pix_x_r / 11'(BAR_W);
        if (bar_full_s > 11'd7) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_full_s[2:0];
        end
        rgb_sel_s = {{CW{bar_idx_s[2]}}, {CW{bar_idx_s[1]}}, {CW{bar_idx_s[0]}}};
    end
`else
    // Upstream pixel data passes straight to the output stage.
    always_comb begin
        rgb_sel_s = rgb_in;
    end
`endif

    // Stage 2: pin registers; RGB forced to zero outside active video.
    always_ff @(posedge fpga_CLK) begin
        if (fpga_RST) begin
            vga_rgb_r <= {(3*CW){1'b0}};
            vga_hs_r  <= ~HS_ON;
            vga_vs_r  <= ~VS_ON;
            vga_de_r  <= 1'b0;
        end else if (pix_en) begin
            vga_rgb_r <= de1_r ? rgb_sel_s : {(3*CW){1'b0}};
            vga_hs_r  <= hs1_r ? HS_ON : ~HS_ON;
            vga_vs_r  <= vs1_r ? VS_ON : ~VS_ON;
            vga_de_r  <= de1_r;
        end
    end

    assign pix_req     = pix_req_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign frame_start = frame_start_r;
    assign vga_RGB     = vga_rgb_r;
    assign vga_HS      = vga_hs_r;
    assign vga_VS      = vga_vs_r;
    assign vga_DE      = vga_de_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a tick-count raster model on a
// shrunken timing so several frames fit; handles VGA_TIMING_TEST_PATTERN_EN too.
module tb_vga_timing_gen;

    localparam int H_DISP = 16;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 2;
    localparam int V_DISP = 6;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int CW     = 8;
    localparam int HT     = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = HT * VT;
    localparam logic HS_ON = 1'b0;
    localparam logic VS_ON = 1'b1;

    logic               fpga_CLK = 1'b0;
    logic               fpga_RST = 1'b1;
    logic               pix_en   = 1'b0;
    logic [3*CW-1:0]    rgb_in   = 24'h000000;
    logic               pix_req;
    logic [10:0]        pix_x;
    logic [9:0]         pix_y;
    logic               frame_start;
    logic [3*CW-1:0]    vga_RGB;
    logic               vga_HS;
    logic               vga_VS;
    logic               vga_DE;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k        = 0;
    logic [23:0] exp_rgb  = 24'h000000;
    logic        exp_fs   = 1'b0;
    bit          count_win = 1'b0;
    int          de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;

    vga_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(1), .CW(CW)
    ) dut (
        .fpga_CLK(fpga_CLK), .fpga_RST(fpga_RST), .pix_en(pix_en),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .rgb_in(rgb_in), .vga_RGB(vga_RGB),
        .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_DE(vga_DE)
    );

    always #5 fpga_CLK = ~fpga_CLK;

    // Raster position n (0-based count of positions since reset).
    function automatic int px(input int n);
        return (n % FRAME) % HT;
    endfunction

    function automatic int py(input int n);
        return (n % FRAME) / HT;
    endfunction

    function automatic bit in_act(input int n);
        return (px(n) < H_DISP) && (py(n) < V_DISP);
    endfunction

    function automatic bit hs_in(input int n);
        return (px(n) >= H_DISP + H_FP) && (px(n) < H_DISP + H_FP + H_SYNC);
    endfunction

    function automatic bit vs_in(input int n);
        return (py(n) >= V_DISP + V_FP) && (py(n) < V_DISP + V_FP + V_SYNC);
    endfunction

    function automatic logic [23:0] bar_rgb(input int x);
        int b;
        b = x / (H_DISP / 8);
        if (b > 7) b = 7;
        return {((b / 4) % 2 == 1) ? 8'hFF : 8'h00,
                ((b / 2) % 2 == 1) ? 8'hFF : 8'h00,
                (b % 2 == 1)       ? 8'hFF : 8'h00};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input bit rst, input bit en);
        logic e_req, e_hs, e_vs, e_de;
        int   e_x, e_y;
        fpga_RST = rst;
        pix_en   = en;
        @(posedge fpga_CLK);
        #1;
        if (rst) begin
            k = 0;
            exp_rgb = 24'h000000;
            exp_fs = 1'b0;
        end else if (en) begin
            if (k >= 1 && in_act(k - 1)) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
                exp_rgb = bar_rgb(px(k - 1));
`else
                exp_rgb = rgb_in;
`endif
            end else begin
                exp_rgb = 24'h000000;
            end
            exp_fs = ((k % FRAME) == 0);
            k++;
        end else begin
            exp_fs = 1'b0;
        end

        if (k >= 1) begin
            e_req = in_act(k - 1); e_x = px(k - 1); e_y = py(k - 1);
        end else begin
            e_req = 1'b0; e_x = 0; e_y = 0;
        end
        if (k >= 2) begin
            e_hs = hs_in(k - 2) ? HS_ON : ~HS_ON;
            e_vs = vs_in(k - 2) ? VS_ON : ~VS_ON;
            e_de = in_act(k - 2);
        end else begin
            e_hs = ~HS_ON; e_vs = ~VS_ON; e_de = 1'b0;
        end

        check_eq("pix_req", 32'(pix_req), 32'(e_req));
        check_eq("pix_x", 32'(pix_x), 32'(e_x));
        check_eq("pix_y", 32'(pix_y), 32'(e_y));
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
        check_eq("vga_HS", 32'(vga_HS), 32'(e_hs));
        check_eq("vga_VS", 32'(vga_VS), 32'(e_vs));
        check_eq("vga_DE", 32'(vga_DE), 32'(e_de));
        check_eq("vga_RGB", 32'(vga_RGB), 32'(exp_rgb));

        if (count_win) begin
            if (k >= 2 && k <= FRAME + 1) begin
                if (vga_DE) de_cnt++;
                if (vga_HS == HS_ON) hs_cnt++;
                if (vga_VS == VS_ON) vs_cnt++;
            end
            if (frame_start) fs_cnt++;
        end

        if (k >= 1) begin
            rgb_in = {8'(py(k - 1)), 8'(px(k - 1)), 8'($urandom_range(0, 255))};
        end else begin
            rgb_in = {16'h0000, 8'($urandom_range(0, 255))};
        end
    endtask

    initial begin
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Continuous enable, then a one-clock reset inside both sync pulses.
        count_win = 1'b1;
        while (k < FRAME + (V_DISP + V_FP) * HT + H_DISP + H_FP + 3) begin
            step(1'b0, 1'b1);
        end
        count_win = 1'b0;
        check_eq("de_per_frame", 32'(de_cnt), 32'(H_DISP * V_DISP));
        check_eq("hs_per_frame", 32'(hs_cnt), 32'(H_SYNC * VT));
        check_eq("vs_per_frame", 32'(vs_cnt), 32'(V_SYNC * HT));
        check_eq("frame_pulses", 32'(fs_cnt), 32'd2);
        step(1'b1, 1'b1);
        repeat (3 * HT) step(1'b0, 1'b1);

        // One-in-four pixel enable.
        for (int i = 0; i < 4 * FRAME + 40; i++) begin
            step(1'b0, (i % 4) == 0);
        end

        // Random enable with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        step(1'b1, 1'b0);
        repeat (FRAME + 10) step(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA raster timing and output stage for the video controller: generates horizontal/vertical counters, sync, and data-enable from a pixel-rate enable. It requests pixels from the upstream frame source and drives the registered RGB/sync pins of the DAC/connector. It sits between the clock/reset top level and the video output pins, consuming pixel data and producing the physical VGA signals.

## Interface
Parameters:
- H_DISP, 640: active pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch
- V_DISP, 480: active lines
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch
- HS_POL, 0: hsync active level
- VS_POL, 0: vsync active level
- CW, 8: bits per colour channel

Ports:
- fpga_CLK  in  1  system clock
- fpga_RST  in  1  reset; one clock, synchronous, active-high
- pix_en  in  1  pixel-rate enable; all state advances only when high
- pix_req  out  1  pixel request; high while (pix_x, pix_y) is in the active area
- pix_x  out  11  requested pixel column
- pix_y  out  10  requested pixel line
- frame_start  out  1  one-clock pulse at raster position (0,0)
- rgb_in  in  3*CW  upstream pixel {R,G,B}, valid one enabled tick after pix_req
- vga_RGB  out  3*CW  output pixel
- vga_HS  out  1  horizontal sync
- vga_VS  out  1  vertical sync
- vga_DE  out  1  output data-enable (active video)

## Operation
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Stage 0: hcnt (11b), vcnt (10b). On pix_en: hcnt increments; at H_TOTAL-1 wraps to 0 and vcnt increments; vcnt wraps V_TOTAL-1 → 0 when hcnt wraps.
- Decode: active = hcnt<H_DISP && vcnt<V_DISP; hs_act = H_DISP+H_FP ≤ hcnt < H_DISP+H_FP+H_SYNC; vs_act analogous on vcnt.
- Stage 1 (registered on pix_en): pix_req=active, pix_x=hcnt, pix_y=vcnt, internal hs1/vs1/de1. pix_x/pix_y reflect raw counters including blanking.
- frame_start: registered, high for exactly one fpga_CLK cycle, on the clock where stage 1 loads hcnt=0, vcnt=0 (gated by pix_en).
- Stage 2 (registered on pix_en): vga_HS = hs1 ? HS_POL : ~HS_POL; vga_VS likewise; vga_DE = de1; vga_RGB = de1 ? rgb_in : 0.
- Upstream contract: samples pix_req/pix_x/pix_y on an enabled tick, presents rgb_in stable before the next enabled tick. No back-pressure; data is consumed unconditionally.

## Timing
- Reset (fpga_RST high at a fpga_CLK edge) overrides pix_en: hcnt=vcnt=0, pix_req=0, pix_x=pix_y=0, frame_start=0, vga_RGB=0, vga_DE=0, vga_HS=~HS_POL, vga_VS=~VS_POL.
- First enabled tick after reset loads stage 1 with (0,0): pix_req=1, frame_start=1.
- Latency: counters → pix_* 1 enabled tick; pix_* → vga_* 1 enabled tick; syncs and DE stay aligned with the RGB they qualify.
- pix_en low: all registers hold; frame_start deasserts after its single cycle and never re-pulses while held.
- Reset mid-frame: raster restarts at (0,0); no partial sync pulse extended.
- Parameter legality: every porch/sync ≥1; H_TOTAL < 2048, V_TOTAL < 1024.

## Configuration
- VGA_TIMING_TEST_PATTERN_EN defined: stage 2 ignores rgb_in; during DE outputs 8 vertical colour bars, bar index = pix_x_delayed / (H_DISP/8), bar colour {R,G,B} = each channel all-ones or zero from index bits {2,1,0} (bar 0 black, bar 7 white); blanking still 0. rgb_in port remains, unused.
- Undefined: vga_RGB passes rgb_in as described.

## Test plan
- Reset then pix_en=1 constantly: vga_HS low exactly for hcnt 656..751 (96 clocks) each 800-clock line; vga_VS low for lines 490..491 (1600 clocks); frame period 420000 clocks.
- frame_start: pulses once per 420000 clocks; first pulse one clock after reset release; pix_req high 640 of every 800 clocks on lines 0..479, never on 480..524.
- rgb_in driven = {pix_y[7:0], pix_x[7:0], 8'h5A} registered one tick: vga_RGB at DE equals that pattern for the pixel; 0 whenever vga_DE=0.
- pix_en toggling 1-of-4 clocks: all outputs change only after enabled ticks; line period 3200 clocks; frame_start width still 1 clock.
- Assert fpga_RST at (hcnt=700, vcnt=300) for one clock: next clock syncs inactive (high), vga_DE=0, counters 0; raster restarts from (0,0).
- With VGA_TIMING_TEST_PATTERN_EN: pixel x=0 → 0x000000, x=80 → 0x0000FF, x=639 → 0xFFFFFF regardless of rgb_in.
